// File: rtl/mips_cu_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Holds the state enum, opcodes, ALUOp codes and the datapath mux-select encodings.
package mips_cu_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_ADDI_WB   = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_JAL       = 4'd11
   } state_e;

   localparam int unsigned OP_BITS = 6;
   localparam logic [OP_BITS-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_BITS-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_BITS-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_BITS-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_BITS-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_BITS-1:0] OP_J     = 6'b000010;
   localparam logic [OP_BITS-1:0] OP_JAL   = 6'b000011;

   localparam int unsigned SEL_W = 2;
   localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
   localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
   localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

   localparam logic [SEL_W-1:0] MEMTOREG_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] MEMTOREG_MDR    = 2'b01;
   localparam logic [SEL_W-1:0] MEMTOREG_PC     = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_cu_outdec.sv
// Moore output decoder: maps state (plus mem_ready handshake) to every datapath control.
// Under reset all enables are forced low and the selects show their FETCH values.
module multicycle_cu_outdec
   import mips_cu_pkg::*;
#(
   parameter int unsigned ALUOP_W = 2
) (
   input  state_e             state_i,
   input  logic               mem_ready_i,
   input  logic               rst_n_i,
   output logic               pc_write_o,
   output logic               pc_write_cond_o,
   output logic               i_or_d_o,
   output logic               mem_read_o,
   output logic               mem_write_o,
   output logic               ir_write_o,
   output logic               alu_src_a_o,
   output logic               reg_write_o,
   output logic [SEL_W-1:0]   reg_dst_o,
   output logic [SEL_W-1:0]   mem_to_reg_o,
   output logic [SEL_W-1:0]   alu_src_b_o,
   output logic [SEL_W-1:0]   pc_source_o,
   output logic [ALUOP_W-1:0] alu_op_o,
   output logic               instr_done_o
);

   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      alu_src_a_o     = 1'b0;
      reg_write_o     = 1'b0;
      reg_dst_o       = REGDST_RT;
      mem_to_reg_o    = MEMTOREG_ALUOUT;
      alu_src_b_o     = SRCB_B;
      pc_source_o     = PCSRC_ALU;
      alu_op_o        = ALUOP_W'(ALUOP_ADD);
      instr_done_o    = 1'b0;

      if (!rst_n_i) begin
         alu_src_b_o = SRCB_FOUR;
      end else begin
         unique case (state_i)
            S_FETCH: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = SRCB_FOUR;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
            end
            S_DECODE: alu_src_b_o = SRCB_IMM_SH2;
            S_MEM_ADDR: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = SRCB_IMM;
            end
            S_MEM_READ: begin
               mem_read_o = 1'b1;
               i_or_d_o   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write_o  = 1'b1;
               mem_to_reg_o = MEMTOREG_MDR;
               instr_done_o = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write_o  = 1'b1;
               i_or_d_o     = 1'b1;
               instr_done_o = mem_ready_i;
            end
            S_EXECUTE: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = ALUOP_W'(ALUOP_FUNCT);
            end
            S_ALU_WB: begin
               reg_write_o  = 1'b1;
               reg_dst_o    = REGDST_RD;
               instr_done_o = 1'b1;
            end
            S_ADDI_WB: begin
               reg_write_o  = 1'b1;
               instr_done_o = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a_o     = 1'b1;
               alu_op_o        = ALUOP_W'(ALUOP_SUB);
               pc_write_cond_o = 1'b1;
               pc_source_o     = PCSRC_ALUOUT;
               instr_done_o    = 1'b1;
            end
            S_JUMP: begin
               pc_write_o   = 1'b1;
               pc_source_o  = PCSRC_JUMP;
               instr_done_o = 1'b1;
            end
            // Link PC+4: PC was already incremented during FETCH.
            S_JAL: begin
               pc_write_o   = 1'b1;
               pc_source_o  = PCSRC_JUMP;
               reg_write_o  = 1'b1;
               reg_dst_o    = REGDST_RA;
               mem_to_reg_o = MEMTOREG_PC;
               instr_done_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: state register, opcode-driven sequencing,
// illegal-opcode flag and retired-instruction counter.
module multicycle_cu
   import mips_cu_pkg::*;
#(
   parameter int unsigned OPCODE_W = 6,
   parameter int unsigned ALUOP_W  = 2,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                ALUSrcA,
   output logic                RegWrite,
   output logic [1:0]          RegDst,
   output logic [1:0]          MemtoReg,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          PCSource,
   output logic [ALUOP_W-1:0]  ALUOp,
   output logic                illegal_op,
   output logic                instr_done,
   output logic [CNT_W-1:0]    retired
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  retired_q;
   logic              op_legal_c;
   logic              instr_done_c;

   // Reset has priority, so an aborted instruction never counts as retired.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (instr_done_c) retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      op_legal_c = 1'b1;
      unique case (state_q)
         S_FETCH:     if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            unique case (opcode)
               OPCODE_W'(OP_RTYPE): state_d = S_EXECUTE;
               OPCODE_W'(OP_LW),
               OPCODE_W'(OP_SW),
               OPCODE_W'(OP_ADDI):  state_d = S_MEM_ADDR;
               OPCODE_W'(OP_BEQ):   state_d = S_BRANCH;
               OPCODE_W'(OP_J):     state_d = S_JUMP;
               OPCODE_W'(OP_JAL):   state_d = S_JAL;
               default: begin
                  state_d    = S_FETCH;
                  op_legal_c = 1'b0;
               end
            endcase
         end
         S_MEM_ADDR: begin
            if (opcode == OPCODE_W'(OP_LW))        state_d = S_MEM_READ;
            else if (opcode == OPCODE_W'(OP_SW))   state_d = S_MEM_WRITE;
            else if (opcode == OPCODE_W'(OP_ADDI)) state_d = S_ADDI_WB;
            else                                   state_d = S_FETCH;
         end
         S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTE:   state_d = S_ALU_WB;
         default:     state_d = S_FETCH;
      endcase
   end

   multicycle_cu_outdec #(
      .ALUOP_W(ALUOP_W)
   ) u_outdec (
      .state_i         (state_q),
      .mem_ready_i     (mem_ready),
      .rst_n_i         (rst_n),
      .pc_write_o      (PCWrite),
      .pc_write_cond_o (PCWriteCond),
      .i_or_d_o        (IorD),
      .mem_read_o      (MemRead),
      .mem_write_o     (MemWrite),
      .ir_write_o      (IRWrite),
      .alu_src_a_o     (ALUSrcA),
      .reg_write_o     (RegWrite),
      .reg_dst_o       (RegDst),
      .mem_to_reg_o    (MemtoReg),
      .alu_src_b_o     (ALUSrcB),
      .pc_source_o     (PCSource),
      .alu_op_o        (ALUOp),
      .instr_done_o    (instr_done_c)
   );

   assign instr_done = instr_done_c;
   assign illegal_op = rst_n & ~op_legal_c;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: per-instruction expected control
// sequences built from the instruction's phase list, with randomized wait states.
module tb_multicycle_cu;

   localparam int PH_FETCH = 0, PH_DEC = 1, PH_ADDR = 2, PH_RD = 3, PH_MWB = 4,
                  PH_WR = 5, PH_EX = 6, PH_AWB = 7, PH_IWB = 8, PH_BR = 9,
                  PH_J = 10, PH_JAL = 11, PH_RST = 12;

   typedef struct packed {
      logic       pcw, pcwc, iord, mr, mw, irw, srca, rw;
      logic [1:0] regdst, m2r, srcb, pcsrc, aluop;
      logic       ill, done;
   } ctl_t;

   typedef struct {
      ctl_t       c;
      logic       rdy;
      logic       opm;
      logic [5:0] op;
   } step_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic mem_ready = 1'b0;

   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite;
   logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp;
   logic illegal_op, instr_done;
   logic [31:0] retired;

   logic w_pcw, w_pcwc, w_iord, w_mr, w_mw, w_irw, w_srca, w_rw;
   logic [1:0] w_regdst, w_m2r, w_srcb, w_pcsrc, w_aluop;
   logic w_ill, w_done;
   logic [3:0] retired4;

   int checks = 0;
   int passed = 0;
   logic [31:0] retired_m = '0;
   step_t q[$];

   always #5 clk = ~clk;

   multicycle_cu #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUOp(ALUOp), .illegal_op(illegal_op), .instr_done(instr_done), .retired(retired)
   );

   multicycle_cu #(.OPCODE_W(6), .ALUOP_W(2), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(w_pcw), .PCWriteCond(w_pcwc), .IorD(w_iord), .MemRead(w_mr),
      .MemWrite(w_mw), .IRWrite(w_irw), .ALUSrcA(w_srca), .RegWrite(w_rw),
      .RegDst(w_regdst), .MemtoReg(w_m2r), .ALUSrcB(w_srcb), .PCSource(w_pcsrc),
      .ALUOp(w_aluop), .illegal_op(w_ill), .instr_done(w_done), .retired(retired4)
   );

   function automatic ctl_t obs();
      ctl_t c;
      c = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite,
            RegDst, MemtoReg, ALUSrcB, PCSource, ALUOp, illegal_op, instr_done};
      return c;
   endfunction

   function automatic logic legal(input logic [5:0] op);
      return op inside {6'd0, 6'd35, 6'd43, 6'd8, 6'd4, 6'd2, 6'd3};
   endfunction

   // Expected controls for one clock of a given instruction phase.
   function automatic ctl_t exp_ctl(input int ph, input logic rdy, input logic ill);
      ctl_t c;
      c = '0;
      case (ph)
         PH_FETCH: begin c.mr = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
         PH_DEC:   begin c.srcb = 2'b11; c.ill = ill; end
         PH_ADDR:  begin c.srca = 1; c.srcb = 2'b10; end
         PH_RD:    begin c.mr = 1; c.iord = 1; end
         PH_MWB:   begin c.rw = 1; c.m2r = 2'b01; c.done = 1; end
         PH_WR:    begin c.mw = 1; c.iord = 1; c.done = rdy; end
         PH_EX:    begin c.srca = 1; c.aluop = 2'b10; end
         PH_AWB:   begin c.rw = 1; c.regdst = 2'b01; c.done = 1; end
         PH_IWB:   begin c.rw = 1; c.done = 1; end
         PH_BR:    begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; c.done = 1; end
         PH_J:     begin c.pcw = 1; c.pcsrc = 2'b10; c.done = 1; end
         PH_JAL:   begin c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1; c.regdst = 2'b10;
                         c.m2r = 2'b10; c.done = 1; end
         default:  c.srcb = 2'b01;
      endcase
      return c;
   endfunction

   // rdy < 0: mem_ready is irrelevant in this phase, drive a random value.
   task automatic add(input int ph, input int rdy, input logic opm, input logic [5:0] op);
      step_t s;
      s.rdy = (rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy);
      s.opm = opm;
      s.op  = op;
      s.c   = exp_ctl(ph, s.rdy, !legal(op));
      q.push_back(s);
   endtask

   task automatic build(input logic [5:0] op, input int wf, input int wm);
      for (int i = 0; i < wf; i++) add(PH_FETCH, 0, 0, op);
      add(PH_FETCH, 1, 0, op);
      add(PH_DEC, -1, 1, op);
      case (op)
         6'd0:  begin add(PH_EX, -1, 0, op); add(PH_AWB, -1, 0, op); end
         6'd35: begin
            add(PH_ADDR, -1, 1, op);
            for (int i = 0; i < wm; i++) add(PH_RD, 0, 0, op);
            add(PH_RD, 1, 0, op);
            add(PH_MWB, -1, 0, op);
         end
         6'd43: begin
            add(PH_ADDR, -1, 1, op);
            for (int i = 0; i < wm; i++) add(PH_WR, 0, 0, op);
            add(PH_WR, 1, 0, op);
         end
         6'd8:  begin add(PH_ADDR, -1, 1, op); add(PH_IWB, -1, 0, op); end
         6'd4:  add(PH_BR, -1, 0, op);
         6'd2:  add(PH_J, -1, 0, op);
         6'd3:  add(PH_JAL, -1, 0, op);
         default: ;
      endcase
   endtask

   // Entered just after a falling edge; plays n steps (all if n < 0), checks each.
   task automatic run_seq(input int n);
      int lim;
      lim = (n < 0) ? q.size() : n;
      for (int k = 0; k < lim; k++) begin
         opcode    = q[k].opm ? q[k].op : 6'($urandom);
         mem_ready = q[k].rdy;
         #1;
         checks++;
         if (obs() !== q[k].c)
            $display("FAIL ctl step %0d op=%b: got %h, expected %h", k, q[k].op, obs(), q[k].c);
         else passed++;
         @(posedge clk);
         if (q[k].c.done) retired_m++;
         @(negedge clk);
      end
      q.delete();
      #1;
      checks++;
      if (retired !== retired_m) $display("FAIL retired: got %0d, expected %0d", retired, retired_m);
      else passed++;
      checks++;
      if (retired4 !== retired_m[3:0])
         $display("FAIL retired4: got %0d, expected %0d", retired4, retired_m[3:0]);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ready = 1'b1;
      opcode = 6'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== exp_ctl(PH_RST, 1, 0))
         $display("FAIL reset_ctl: got %h, expected %h", obs(), exp_ctl(PH_RST, 1, 0));
      else passed++;
      checks++;
      if (retired !== 32'd0) $display("FAIL reset_retired: got %0d, expected 0", retired);
      else passed++;
      rst_n = 1'b1;
      retired_m = '0;
   endtask

   task automatic test_rtype();
      build(6'd0, 0, 0);
      run_seq(-1);
      checks++;
      if (retired !== 32'd1) $display("FAIL rtype_retired: got %0d, expected 1", retired);
      else passed++;
   endtask

   task automatic test_lw_wait();
      build(6'd35, 0, 2);
      run_seq(-1);
   endtask

   task automatic test_back_to_back();
      logic [31:0] r0;
      r0 = retired_m;
      build(6'd43, 0, 0);
      build(6'd4, 0, 0);
      build(6'd2, 0, 0);
      run_seq(-1);
      checks++;
      if (retired !== r0 + 32'd3) $display("FAIL b2b_retired: got %0d, expected %0d", retired, r0 + 3);
      else passed++;
   endtask

   task automatic test_jal();
      build(6'd3, 1, 0);
      run_seq(-1);
   endtask

   task automatic test_illegal();
      logic [31:0] r0;
      r0 = retired_m;
      build(6'b111111, 0, 0);
      build(6'd8, 0, 0);
      run_seq(-1);
      checks++;
      if (retired !== r0 + 32'd1) $display("FAIL illegal_retired: got %0d, expected %0d", retired, r0 + 1);
      else passed++;
   endtask

   task automatic test_random(input int n, input logic only_legal);
      logic [5:0] ops [7];
      logic [5:0] op;
      ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd4, 6'd2, 6'd3};
      for (int i = 0; i < n; i++) begin
         if (!only_legal && $urandom_range(0, 7) == 0) op = 6'($urandom);
         else op = ops[$urandom_range(0, 6)];
         build(op, $urandom_range(0, 2), $urandom_range(0, 2));
         run_seq(-1);
      end
   endtask

   task automatic test_reset_mid();
      build(6'd35, 1, 1);
      run_seq(q.size() - 1);
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (obs() !== exp_ctl(PH_RST, 1, 0))
         $display("FAIL midreset_ctl: got %h, expected %h", obs(), exp_ctl(PH_RST, 1, 0));
      else passed++;
      @(posedge clk);
      retired_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (obs() !== exp_ctl(PH_FETCH, 1, 0))
         $display("FAIL midreset_fetch: got %h, expected %h", obs(), exp_ctl(PH_FETCH, 1, 0));
      else passed++;
      checks++;
      if (retired !== 32'd0 || retired4 !== 4'd0)
         $display("FAIL midreset_retired: got %0d/%0d, expected 0", retired, retired4);
      else passed++;
   endtask

   task automatic test_wrap();
      test_random(16, 1'b1);
      checks++;
      if (retired4 !== 4'd0 || retired !== 32'd16)
         $display("FAIL wrap: got %0d/%0d, expected 0/16", retired4, retired);
      else passed++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_rtype();
      test_lw_wait();
      test_back_to_back();
      test_jal();
      test_illegal();
      test_random(40, 1'b0);
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_cu.md
# multicycle_cu

Multi-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several clocks for R-type, lw, sw, addi, beq, j and jal. It sits beside the shared-ALU/shared-memory datapath (PC, IR, MDR, A/B, ALUOut registers) and drives every mux select and write enable there. It replaces the single-cycle decoder with these additions:
- A memory-ready handshake (wait states).
- JAL link write-back.
- Illegal-opcode reporting.
- A retired-instruction counter.

## Interface
Parameters:
- OPCODE_W, 6, opcode width (IR[31:26]).
- ALUOP_W, 2, ALUOp width to the ALU-control block.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- opcode  in  OPCODE_W  IR opcode field, stable from the cycle after FETCH completes.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite  out  1 each  datapath controls.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded.
- illegal_op  out  1  unknown opcode seen in DECODE.
- instr_done  out  1  last cycle of a legal instruction.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Outputs are combinational from state (plus the mem_ready gating below). Any control not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready.
  - Stay while !mem_ready; go to DECODE on mem_ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 → EXECUTE
  - 100011, 101011, 001000 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 000011 → JAL
  - any other → FETCH with illegal_op=1 for this cycle
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw→MEM_READ, sw→MEM_WRITE, addi→ADDI_WB.
- MEM_READ: MemRead=1, IorD=1. Hold until mem_ready, then → MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01 → FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold until mem_ready, then → FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALU_WB.
- ALU_WB: RegWrite=1, RegDst=01, MemtoReg=00 → FETCH.
- ADDI_WB: RegWrite=1, RegDst=00, MemtoReg=00 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- JAL: as JUMP, plus RegWrite=1, RegDst=10, MemtoReg=10. Links PC+4, since PC was already incremented in FETCH.
- instr_done=1 in MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP, JAL, and in MEM_WRITE when mem_ready=1.
- retired increments by 1 on each clock where instr_done=1. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset (rst_n=0 at a rising edge): state←FETCH, retired←0.
- While rst_n=0, combinationally force PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op and instr_done to 0. The remaining selects show FETCH values.
- Reset asserted mid-instruction aborts it: no write enable is asserted after the edge, and retired does not increment on that edge.
- Cycles per instruction with mem_ready held 1:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3, jal 3.
  - Illegal opcode: 2 cycles.
- Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. Controls are held constant during the wait.
- mem_ready is ignored in all other states.
- opcode is sampled only in DECODE and MEM_ADDR.

## Structure
- Package mips_cu_pkg holds:
  - the state enum (12 states, 4-bit encoding);
  - opcode localparams OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J, OP_JAL;
  - ALUOp localparams ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - 2-bit mux-select constants for RegDst, MemtoReg, ALUSrcB and PCSource.
- One sub-module, multicycle_cu_outdec: purely combinational, mapping state plus mem_ready to all controls.
- The top level holds the state register, next-state logic and the retired counter.

## Test plan
- Reset, then R-type (opcode 0), mem_ready=1:
  - states go FETCH→DECODE→EXECUTE→ALU_WB.
  - RegWrite=1 with RegDst=01 only in cycle 4.
  - retired=1 after cycle 4.
- lw (100011) with mem_ready low for 2 cycles in MEM_READ:
  - total 7 cycles; MemRead and IorD stay 1 throughout the wait.
  - MEM_WB shows MemtoReg=01.
- sw, then beq, then j back-to-back:
  - 4+3+3 cycles.
  - MemWrite=1 in exactly one cycle with mem_ready=1.
  - PCWriteCond=1 only in BRANCH; PCSource=10 in JUMP.
  - retired=3.
- jal (000011): in its third cycle PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10.
- Opcode 111111: illegal_op=1 in DECODE, next state FETCH, instr_done=0, retired unchanged.
- CNT_W=4 with 16 instructions: retired wraps to 0. rst_n=0 asserted in MEM_WB: no RegWrite, state FETCH next cycle, retired=0.
